conv_stream: RTL and testbench
==============================

CONV_STREAM -- requirements
Module: conv_stream

Interface
REQ-001 The module SHALL take parameter DWIDTH, default 8, unsigned pixel width.
REQ-002 The module SHALL take parameter LINE_W, default 320, pixels per line (>=4).
REQ-003 The module SHALL take parameter KWIDTH, default 4, signed two's-complement coefficient width.
REQ-004 The module SHALL take parameter SWIDTH, default 4, normalisation shift width.
REQ-005 The module SHALL have port sys_clk, input, 1, sole clock; all logic rising-edge.
REQ-006 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The module SHALL have port s_valid, input, 1, input pixel valid.
REQ-008 The module SHALL have port s_ready, output, 1, input pixel accepted when s_valid&s_ready.
REQ-009 The module SHALL have port s_sof, input, 1, accompanies first pixel of a frame.
REQ-010 The module SHALL have port s_data, input, DWIDTH, raster-order pixel.
REQ-011 The module SHALL have port kernel, input, 9*KWIDTH, coefficient k[i] at bits [i*KWIDTH +: KWIDTH]; i=3*row+col, row 0 oldest line, col 0 oldest pixel.
REQ-012 The module SHALL have port shift, input, SWIDTH, arithmetic right-shift applied to the sum.
REQ-013 The module SHALL have port pass_thru, input, 1, bypass convolution.
REQ-014 The module SHALL have ports m_valid (output, 1), m_ready (input, 1), and m_data (output, DWIDTH) for the result stream.

Function
REQ-015 Two line buffers of LINE_W x DWIDTH SHALL hold the previous two lines; a 3x3 window register SHALL shift on every accepted pixel.
REQ-016 Column counter SHALL count 0..LINE_W-1 and wrap to 0; row counter SHALL increment on column wrap and saturate at 2.
REQ-017 An accepted pixel with s_sof=1 SHALL be treated as position (0,0) and clear both counters, including mid-line.
REQ-018 kernel and shift SHALL be latched only on an accepted s_sof pixel; changes mid-frame SHALL have no effect until the next s_sof.
REQ-019 Exactly one output pixel SHALL be produced per accepted input pixel, in order, with none dropped or duplicated.
REQ-020 Output for input at (r,c) SHALL be the window centred at (r-1,c-1); if r<2 or c<2 the output SHALL be 0.
REQ-021 Sum SHALL be signed, width DWIDTH+KWIDTH+5: sum of 9 products (unsigned pixel x signed coefficient), then arithmetic shift right by latched shift.
REQ-022 The shifted result SHALL be clamped to [0, 2^DWIDTH-1].
REQ-023 With pass_thru=1, m_data SHALL equal the accepted input pixel at identical latency, with no border zeroing; pass_thru SHALL be sampled per pixel.
REQ-024 The pipeline SHALL have two stages (window/products, sum/normalise); m_valid SHALL assert 2 cycles after acceptance when m_ready stays high.
REQ-025 Advance enable SHALL be adv = m_ready | ~m_valid; s_ready SHALL equal adv; both stages SHALL hold when adv=0.
REQ-026 While m_valid=1 and m_ready=0, m_data SHALL remain stable.
REQ-027 With sustained s_valid and m_ready, throughput SHALL be one pixel per cycle.

Reset
REQ-028 On rst=1 at a clock edge, m_valid, m_data, counters, latched kernel and latched shift SHALL clear to 0, and stage valids SHALL clear.
REQ-029 Line buffer contents SHALL NOT be reset; border zeroing SHALL mask stale data.
REQ-030 Reset mid-frame SHALL discard in-flight pixels; m_valid SHALL be 0 the cycle after reset.

Configuration
REQ-031 With macro CONV_ABS_EN defined, a negative sum SHALL be replaced by its magnitude before shifting (edge-magnitude mode).
REQ-032 Without CONV_ABS_EN, no absolute-value logic SHALL exist and negative results SHALL clamp to 0 per REQ-022.

Verification (LINE_W=8, DWIDTH=8, KWIDTH=4)
REQ-033 Identity kernel (k[4]=1, others 0), shift 0, 8x4 frame with pixel=10r+c -> out(r,c)=10(r-1)+(c-1) for r,c>=2, else 0.
REQ-034 All coefficients 1, shift 3, constant 200 -> interior outputs (1800>>3)=225; all coefficients 7, shift 0, constant 255 -> 255 (saturate).
REQ-035 All coefficients -1, shift 2, constant 100 -> interior 0 without CONV_ABS_EN, 225 with it.
REQ-036 m_ready low for 5 cycles mid-line -> s_ready low and m_data stable throughout; output sequence identical to the no-stall run.
REQ-037 Change kernel mid-frame -> outputs unchanged until next s_sof; pass_thru=1 -> m_data equals input 2 cycles later.
REQ-038 rst pulsed mid-frame -> m_valid=0 next cycle; the following frame matches REQ-033 exactly.

Source files
------------

// File: rtl/conv_stream.sv
// Streaming 3x3 convolution over raster pixels with two line buffers and a two-stage pipeline.
// Optional macro CONV_ABS_EN: negative sums are replaced by their magnitude before the shift.
module conv_stream #(
  parameter int DWIDTH = 8,
  parameter int LINE_W = 320,
  parameter int KWIDTH = 4,
  parameter int SWIDTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [DWIDTH-1:0]     s_data,
  input  logic [9*KWIDTH-1:0]   kernel,
  input  logic [SWIDTH-1:0]     shift,
  input  logic                  pass_thru,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DWIDTH-1:0]     m_data
);

  localparam int SUMW = DWIDTH + KWIDTH + 5;
  localparam int CW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);
  localparam logic signed [SUMW-1:0] PIX_MAX = SUMW'((1 << DWIDTH) - 1);

  function automatic logic signed [SUMW-1:0] mul_px(input logic [DWIDTH-1:0] px,
                                                    input logic signed [KWIDTH-1:0] k);
    logic signed [SUMW-1:0] a;
    logic signed [SUMW-1:0] b;
    a = SUMW'(px);
    b = SUMW'(k);
    return a * b;
  endfunction

  function automatic logic [DWIDTH-1:0] sat_px(input logic signed [SUMW-1:0] v);
    if (v < 0) return '0;
    if (v > PIX_MAX) return PIX_MAX[DWIDTH-1:0];
    return v[DWIDTH-1:0];
  endfunction

  logic                      w_adv;
  logic                      w_acc;
  logic [CW-1:0]             w_col;
  logic [1:0]                w_row;
  logic [CW-1:0]             r_col;
  logic [1:0]                r_row;
  logic [9*KWIDTH-1:0]       r_kern;
  logic [SWIDTH-1:0]         r_shift;
  logic [DWIDTH-1:0]         r_lb1 [LINE_W];
  logic [DWIDTH-1:0]         r_lb2 [LINE_W];
  logic [DWIDTH-1:0]         r_win_p0 [9];
  logic [DWIDTH-1:0]         r_pix_p0;
  logic                      r_pt_p0;
  logic                      r_inner_p0;
  logic                      r_vld_p0;
  logic signed [SUMW-1:0]    w_sum;
  logic signed [SUMW-1:0]    w_mag;
  logic signed [SUMW-1:0]    w_norm;
  logic [DWIDTH-1:0]         w_res;

  assign w_adv   = m_ready | ~m_valid;
  assign s_ready = w_adv;
  assign w_acc   = s_valid & w_adv;
  // A start-of-frame pixel is always position (0,0), even mid-line.
  assign w_col   = s_sof ? '0 : r_col;
  assign w_row   = s_sof ? '0 : r_row;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_kern   <= '0;
      r_shift  <= '0;
      r_vld_p0 <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      if (w_acc) begin
        r_col <= (w_col == LAST_COL) ? '0 : w_col + 1'b1;
        r_row <= (w_col == LAST_COL && w_row != 2'd2) ? w_row + 1'b1 : w_row;
        if (s_sof) begin
          r_kern  <= kernel;
          r_shift <= shift;
        end
      end
      if (w_adv) begin
        r_vld_p0 <= w_acc;
        // ---- stage 1: sum / normalise / clamp ----
        m_valid  <= r_vld_p0;
        if (r_vld_p0) m_data <= r_pt_p0 ? r_pix_p0 : w_res;
      end
    end
  end

  // ---- stage 0: line buffers and 3x3 window ----
  always_ff @(posedge sys_clk) begin
    if (w_acc) begin
      r_lb1[w_col] <= s_data;
      r_lb2[w_col] <= r_lb1[w_col];
      for (int r = 0; r < 3; r++) begin
        r_win_p0[3*r]   <= r_win_p0[3*r+1];
        r_win_p0[3*r+1] <= r_win_p0[3*r+2];
      end
      r_win_p0[2] <= r_lb2[w_col];
      r_win_p0[5] <= r_lb1[w_col];
      r_win_p0[8] <= s_data;
      r_pix_p0    <= s_data;
      r_pt_p0     <= pass_thru;
      r_inner_p0  <= (w_row == 2'd2) && (w_col >= CW'(2));
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + mul_px(r_win_p0[i], r_kern[i*KWIDTH +: KWIDTH]);
    end
  end

`ifdef CONV_ABS_EN
  assign w_mag = (w_sum < 0) ? -w_sum : w_sum;
`else
  assign w_mag = w_sum;
`endif

  assign w_norm = w_mag >>> r_shift;
  // Border positions see stale line-buffer data, so they are forced to zero.
  assign w_res  = r_inner_p0 ? sat_px(w_norm) : '0;

endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream: a frame model pushes expected pixels on acceptance,
// a monitor pops and compares on every output transfer.
module tb_conv_stream;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int KW = 4;
  localparam int SW = 4;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic              s_sof;
  logic [DW-1:0]     s_data;
  logic [9*KW-1:0]   kernel;
  logic [SW-1:0]     shift;
  logic              pass_thru;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int img[16][LW];
  int mk[9];
  int msh;
  int mr;
  int mc;

  always #5 sys_clk = ~sys_clk;

  conv_stream #(.DWIDTH(DW), .LINE_W(LW), .KWIDTH(KW), .SWIDTH(SW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .kernel(kernel), .shift(shift), .pass_thru(pass_thru),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_push(input int pix, input logic sof, input logic pt);
    int s;
    logic signed [KW-1:0] kt;
    if (sof) begin
      mr = 0;
      mc = 0;
      for (int i = 0; i < 9; i++) begin
        kt = kernel[i*KW +: KW];
        mk[i] = kt;
      end
      msh = int'(shift);
    end
    img[mr % 16][mc] = pix;
    if (pt) s = pix;
    else if (mr < 2 || mc < 2) s = 0;
    else begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += img[(mr - 2 + i) % 16][mc - 2 + j] * mk[3*i + j];
`ifdef CONV_ABS_EN
      if (s < 0) s = -s;
`endif
      s = s >>> msh;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
    end
    exp_q.push_back(s);
    mc++;
    if (mc == LW) begin
      mc = 0;
      mr++;
    end
  endtask

  task automatic send(input int pix, input logic sof, input logic pt);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data = pix[7:0];
    s_sof = sof;
    pass_thru = pt;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge sys_clk);
      if (s_ready) begin
        model_push(pix, sof, pt);
        done = 1'b1;
      end
      @(posedge sys_clk);
      #1;
    end
    chk("accept_timeout", 32'(done), 1);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic frame(input int rows, input int kind, input int cval, input int ptmode);
    int pix;
    logic pt;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < LW; c++) begin
        pix = (kind == 0) ? 10*r + c : cval;
        pt = (ptmode == 1) ? 1'b1 : (ptmode == 2) ? (c % 2 == 1) : 1'b0;
        send(pix, (r == 0 && c == 0), pt);
      end
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(posedge sys_clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  task automatic stall_seq();
    logic [DW-1:0] held;
    repeat (12) @(posedge sys_clk);
    #1;
    m_ready = 1'b0;
    @(negedge sys_clk);
    held = m_data;
    chk("stall_mvalid", 32'(m_valid), 1);
    chk("stall_sready", 32'(s_ready), 0);
    for (int i = 1; i < 5; i++) begin
      @(posedge sys_clk);
      #1;
      @(negedge sys_clk);
      chk("stall_sready", 32'(s_ready), 0);
      chk("stall_hold", 32'(m_data), 32'(held));
    end
    @(posedge sys_clk);
    #1;
    m_ready = 1'b1;
  endtask

  task automatic set_identity();
    kernel = '0;
    kernel[19:16] = 4'd1;
    shift = '0;
  endtask

  always @(negedge sys_clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_output", 32'(exp_q.size()), 1);
      else chk("pixel", 32'(m_data), exp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    kernel = '0; shift = '0; pass_thru = 1'b0; m_ready = 1'b1;
    mr = 0; mc = 0; msh = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_sready", 32'(s_ready), 1);
    @(posedge sys_clk);
    #1;

    set_identity();
    frame(4, 0, 0, 0); drain();
    kernel = {9{4'h1}}; shift = 4'd3;
    frame(4, 1, 200, 0); drain();
    kernel = {9{4'h7}}; shift = 4'd0;
    frame(4, 1, 255, 0); drain();
    kernel = {9{4'hF}}; shift = 4'd2;
    frame(4, 1, 100, 0); drain();

    set_identity();
    fork
      frame(4, 0, 0, 0);
      stall_seq();
    join
    drain();

    fork
      frame(4, 0, 0, 0);
      begin
        repeat (12) @(posedge sys_clk);
        #1;
        kernel = {9{4'h7}};
        shift = 4'd1;
      end
    join
    drain();

    set_identity();
    frame(4, 0, 0, 2); drain();
    frame(2, 0, 0, 1); drain();

    send(77, 1'b1, 1'b1);
    @(negedge sys_clk);
    chk("lat_cycle1", 32'(m_valid), 0);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("lat_cycle2", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 77);
    drain();

    for (int i = 0; i < 11; i++) send(i, (i == 0), 1'b0);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge sys_clk);
    chk("midrst_mvalid", 32'(m_valid), 0);
    chk("midrst_mdata", 32'(m_data), 0);
    @(posedge sys_clk);
    #1;
    frame(4, 0, 0, 0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
